// File: rtl/alu_op_queue.sv
// Operation FIFO feeding an external combinational ALU, with a one-entry
// registered result stage and a wrapping completed-result counter.
module alu_op_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_a,
    input  logic [3:0]                 in_b,
    input  logic [2:0]                 in_sel,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [2:0]                 alu_sel,
    input  logic [7:0]                 alu_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_y,
    output logic [2:0]                 out_sel,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 done_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          handshake;
    logic          empty;

    assign empty     = (count == '0);
    assign in_ready  = (count < CW'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = !empty && (!out_valid || out_ready) && !flush;
    assign handshake = out_valid && out_ready;

    // Storage is not reset, so the head seen by the ALU is masked while empty.
    assign {alu_a, alu_b, alu_sel} = empty ? 11'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= 8'd0;
            out_sel   <= 3'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_y     <= alu_y;
            out_sel   <= alu_sel;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // A result taken on a flush edge still left the block, so it is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= 8'd0;
        end else if (handshake) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_op_queue.sv
// Bench for alu_op_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_op_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [2:0]    in_sel;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [7:0]    alu_y;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_y;
    logic [2:0]    out_sel;
    logic [CW-1:0] count;
    logic [7:0]    done_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    op_t        m_q[$];
    logic       m_ov;
    logic [7:0] m_y;
    logic [2:0] m_sel;
    logic [7:0] m_done;

    alu_op_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_sel(out_sel),
        .count(count), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s);
        logic [7:0] r;
        case (s)
            3'd0:    r = {4'd0, a} + {4'd0, b};
            3'd1:    r = {4'd0, a} - {4'd0, b};
            3'd2:    r = {4'd0, a & b};
            3'd3:    r = {4'd0, a | b};
            3'd4:    r = {4'd0, a ^ b};
            3'd5:    r = {4'd0, a} << b[1:0];
            3'd6:    r = {4'd0, a} * {4'd0, b};
            default: r = {a, b};
        endcase
        return r;
    endfunction

    always_comb alu_y = ref_alu(alu_a, alu_b, alu_sel);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov   = 1'b0;
        m_y    = 8'd0;
        m_sel  = 3'd0;
        m_done = 8'd0;
    endtask

    // One clock edge of the queue, computed from the acceptance-order rules.
    task automatic model_step();
        logic hs;
        logic pp;
        logic pu;
        op_t  o;
        hs = m_ov && out_ready;
        if (hs) m_done = m_done + 8'd1;
        if (flush) begin
            m_q.delete();
            m_ov = 1'b0;
        end else begin
            pp = (m_q.size() > 0) && (!m_ov || out_ready);
            pu = in_valid && (m_q.size() < DEPTH);
            if (pp) begin
                o     = m_q.pop_front();
                m_ov  = 1'b1;
                m_y   = ref_alu(o.a, o.b, o.sel);
                m_sel = o.sel;
            end else if (hs) begin
                m_ov = 1'b0;
            end
            if (pu) m_q.push_back('{in_a, in_b, in_sel});
        end
    endtask

    task automatic model_compare();
        op_t h;
        h = '{4'd0, 4'd0, 3'd0};
        if (m_q.size() > 0) h = m_q[0];
        check("in_ready", 8'(in_ready), 8'((m_q.size() < DEPTH) && !flush));
        check("out_valid", 8'(out_valid), 8'(m_ov));
        if (m_ov) begin
            check("out_y", out_y, m_y);
            check("out_sel", 8'(out_sel), 8'(m_sel));
        end
        check("count", 8'(count), 8'(m_q.size()));
        check("done_cnt", done_cnt, m_done);
        check("alu_a", 8'(alu_a), 8'(h.a));
        check("alu_b", 8'(alu_b), 8'(h.b));
        check("alu_sel", 8'(alu_sel), 8'(h.sel));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) model_compare();
        end
    end

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] s, input logic ordy, input logic fl);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sel    = s;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12 rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // reset state
        check("rst in_ready", 8'(in_ready), 8'd1);
        check("rst count", 8'(count), 8'd0);
        check("rst out_valid", 8'(out_valid), 8'd0);
        check("rst done_cnt", done_cnt, 8'd0);
        check("rst alu_a", 8'(alu_a), 8'd0);

        // single op, one-cycle latency
        drive(1, 4'd3, 4'd5, 3'd0, 1, 0);
        tick();
        check("s1 count", 8'(count), 8'd1);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        check("s1 out_valid", 8'(out_valid), 8'd1);
        check("s1 out_y", out_y, 8'h08);
        check("s1 out_sel", 8'(out_sel), 8'd0);
        tick();
        check("s1 done_cnt", done_cnt, 8'd1);

        // back-to-back ops
        drive(1, 4'd2, 4'd5, 3'd1, 1, 0);
        tick();
        drive(1, 4'd15, 4'd15, 3'd6, 1, 0);
        tick();
        check("s2 first", out_y, 8'hFD);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        check("s2 second", out_y, 8'hE1);
        check("s2 second sel", 8'(out_sel), 8'd6);
        tick();
        check("s2 done_cnt", done_cnt, 8'd3);

        // fill under backpressure, then drain
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'(i), 4'd1, 3'd0, 0, 0);
            tick();
        end
        check("s3 count full", 8'(count), 8'd4);
        check("s3 in_ready", 8'(in_ready), 8'd0);
        check("s3 held y", out_y, 8'd1);
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("s3 drain y", out_y, 8'(i + 1));
            check("s3 drain count", 8'(count), 8'(4 - i));
        end
        tick();
        check("s3 empty valid", 8'(out_valid), 8'd0);
        check("s3 done_cnt", done_cnt, 8'd8);

        // flush with queued work
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(i), 4'd2, 3'd6, 0, 0);
            tick();
        end
        check("s4 count", 8'(count), 8'd3);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("s4 in_ready flush", 8'(in_ready), 8'd0);
        tick();
        check("s4 out_valid", 8'(out_valid), 8'd0);
        check("s4 count", 8'(count), 8'd0);
        check("s4 done_cnt", done_cnt, 8'd8);
        drive(1, 4'd7, 4'd3, 3'd1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("s4 after flush valid", 8'(out_valid), 8'd1);
        check("s4 after flush y", out_y, 8'd4);
        drive(0, 0, 0, 0, 1, 0);
        tick();

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(i + 1), 4'(i + 1), 3'd4, 0, 0);
            tick();
        end
        check("s5 count", 8'(count), 8'd2);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("s5 out_valid", 8'(out_valid), 8'd0);
        check("s5 out_y", out_y, 8'd0);
        check("s5 count", 8'(count), 8'd0);
        check("s5 done_cnt", done_cnt, 8'd0);
        rst_n = 1'b1;
        drive(1, 4'd9, 4'd9, 3'd0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        check("s5 post valid", 8'(out_valid), 8'd1);
        check("s5 post y", out_y, 8'h12);
        tick();

        // 257 handshakes from reset at full throughput
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 1, 0);
            tick();
            if (i >= 1) check("s6 throughput", 8'(out_valid), 8'd1);
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        check("s6 done_cnt wrap", done_cnt, 8'd1);
        check("s6 count", 8'(count), 8'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (DEPTH + 3) tick();
        check("final count", 8'(count), 8'd0);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
